// File: rtl/pipelined_csel_adder_if.sv
// Stream interface for the pipelined carry-select adder.
// Handshake: a beat moves on a rising edge when valid and ready are both 1;
// valid must not depend on ready, and payload is only meaningful with valid=1.
interface pipelined_csel_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             Sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
   logic             Ovf;

   // Upstream producer / downstream consumer side
   modport master (
      output in_valid, A, B, Cin, Sub, out_ready,
      input  in_ready, out_valid, Sum, Cout, Ovf
   );

   // Adder side
   modport slave (
      input  in_valid, A, B, Cin, Sub, out_ready,
      output in_ready, out_valid, Sum, Cout, Ovf
   );
endinterface

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready stream.
// The WIDTH/BLOCK carry-select blocks are split evenly over STAGES register
// stages; each stage finishes its share of blocks and forwards the partial
// sum, the block carry and the untouched operand bits to the next stage.
module pipelined_csel_adder #(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   pipelined_csel_adder_if.slave bus
);

   localparam int NBLK = WIDTH / BLOCK;
   localparam int BPS  = NBLK / STAGES;

   // Stage registers
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] carry_q;
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic              msb_c_q;

   // Per-stage inputs and next-state values
   logic [STAGES-1:0] in_v;
   logic [STAGES-1:0] in_c;
   logic [WIDTH-1:0]  in_s  [STAGES];
   logic [WIDTH-1:0]  in_a  [STAGES];
   logic [WIDTH-1:0]  in_b  [STAGES];
   logic [STAGES-1:0] carry_d;
   logic [WIDTH-1:0]  sum_d [STAGES];
   logic              msb_c_d;

   // Block-level temporaries
   logic              st_c;
   logic [WIDTH-1:0]  st_s;
   logic [BLOCK-1:0]  blk_a;
   logic [BLOCK-1:0]  blk_b;
   logic [BLOCK:0]    s0;
   logic [BLOCK:0]    s1;
   logic [BLOCK:0]    sel;

   logic              adv;
   logic              unused_hi;

   // The whole pipe moves together; it only stalls when a result is held
   assign adv          = bus.out_ready | ~valid_q[STAGES-1];
   assign bus.in_ready = adv;

   assign bus.out_valid = valid_q[STAGES-1];
   assign bus.Sum       = sum_q[STAGES-1];
   assign bus.Cout      = carry_q[STAGES-1];
   assign bus.Ovf       = msb_c_q ^ carry_q[STAGES-1];

   // Operand bits above the final stage are never consumed
   assign unused_hi = ^{a_q[STAGES-1], b_q[STAGES-1]};

   // Stage inputs: stage 0 takes prepared operands from the ports, later
   // stages take the previous stage register
   always_comb begin
      in_a[0] = bus.A;
      in_b[0] = bus.Sub ? ~bus.B : bus.B;
      in_c[0] = bus.Sub | bus.Cin;
      in_s[0] = '0;
      in_v[0] = bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
         in_a[k] = a_q[k-1];
         in_b[k] = b_q[k-1];
         in_c[k] = carry_q[k-1];
         in_s[k] = sum_q[k-1];
         in_v[k] = valid_q[k-1];
      end
   end

   // Carry-select blocks: both carry-in cases per block, picked by the
   // rippled block carry; the carry into the MSB is captured for overflow
   always_comb begin
      msb_c_d = msb_c_q;
      st_c    = 1'b0;
      st_s    = '0;
      blk_a   = '0;
      blk_b   = '0;
      s0      = '0;
      s1      = '0;
      sel     = '0;
      for (int k = 0; k < STAGES; k++) begin
         st_c = in_c[k];
         st_s = in_s[k];
         for (int j = 0; j < BPS; j++) begin
            blk_a = in_a[k][(k*BPS+j)*BLOCK +: BLOCK];
            blk_b = in_b[k][(k*BPS+j)*BLOCK +: BLOCK];
            s0    = {1'b0, blk_a} + {1'b0, blk_b};
            s1    = {1'b0, blk_a} + {1'b0, blk_b} + {{BLOCK{1'b0}}, 1'b1};
            sel   = st_c ? s1 : s0;
            st_s[(k*BPS+j)*BLOCK +: BLOCK] = sel[BLOCK-1:0];
            if (k*BPS + j == NBLK - 1) begin
               msb_c_d = blk_a[BLOCK-1] ^ blk_b[BLOCK-1] ^ sel[BLOCK-1];
            end
            st_c = sel[BLOCK];
         end
         sum_d[k]   = st_s;
         carry_d[k] = st_c;
      end
   end

   // Stage registers: valid bits advance with the pipe, data only loads
   // behind a real transaction so the outputs hold across bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         carry_q <= '0;
         msb_c_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k] <= '0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
         end
      end else if (adv) begin
         valid_q <= in_v;
         for (int k = 0; k < STAGES; k++) begin
            if (in_v[k]) begin
               sum_q[k]   <= sum_d[k];
               carry_q[k] <= carry_d[k];
               a_q[k]     <= in_a[k];
               b_q[k]     <= in_b[k];
            end
         end
         if (in_v[STAGES-1]) begin
            msb_c_q <= msb_c_d;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder: main (32,4,2) instance with directed
// vectors, streaming, stall and reset, plus three parameter variants fed
// from a shared random stream. Expected results are queued at issue time
// and a monitor pops and compares whenever a result is presented.
module tb_pipelined_csel_adder;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   pipelined_csel_adder_if #(.WIDTH(32)) m_if ();
   pipelined_csel_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(m_if));

   logic        vld_s;
   logic [63:0] a_s, b_s;
   logic        cin_s, sub_s;

   pipelined_csel_adder_if #(.WIDTH(16)) s1_if ();
   pipelined_csel_adder_if #(.WIDTH(64)) s2_if ();
   pipelined_csel_adder_if #(.WIDTH(32)) s3_if ();

   assign s1_if.in_valid = vld_s;  assign s1_if.A = a_s[15:0]; assign s1_if.B = b_s[15:0];
   assign s1_if.Cin = cin_s;       assign s1_if.Sub = sub_s;    assign s1_if.out_ready = 1'b1;
   assign s2_if.in_valid = vld_s;  assign s2_if.A = a_s;        assign s2_if.B = b_s;
   assign s2_if.Cin = cin_s;       assign s2_if.Sub = sub_s;    assign s2_if.out_ready = 1'b1;
   assign s3_if.in_valid = vld_s;  assign s3_if.A = a_s[31:0]; assign s3_if.B = b_s[31:0];
   assign s3_if.Cin = cin_s;       assign s3_if.Sub = sub_s;    assign s3_if.out_ready = 1'b1;

   pipelined_csel_adder #(.WIDTH(16), .BLOCK(4), .STAGES(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .bus(s1_if));
   pipelined_csel_adder #(.WIDTH(64), .BLOCK(8), .STAGES(4)) u_s2 (
      .clk(clk), .rst_n(rst_n), .bus(s2_if));
   pipelined_csel_adder #(.WIDTH(32), .BLOCK(2), .STAGES(8)) u_s3 (
      .clk(clk), .rst_n(rst_n), .bus(s3_if));

   // ---------------- scoreboard ----------------
   // entry layout: {Cout, Ovf, Sum zero-extended to 64 bits}
   logic [65:0] exp_m[$];
   logic [65:0] exp_1[$];
   logic [65:0] exp_2[$];
   logic [65:0] exp_3[$];
   int n_vec   = 0;
   int n_err   = 0;
   int run     = 0;
   int max_run = 0;

   task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [65:0] pk(input logic c, input logic o, input logic [31:0] s);
      return {c, o, 32'h0, s};
   endfunction

   // Reference: plain wide addition, overflow from operand/result signs
   function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic cin, input logic sub, input int w);
      logic [63:0] mask, am, bp, s;
      logic [64:0] full;
      logic        c, o;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      am   = a & mask;
      bp   = (sub ? ~b : b) & mask;
      full = {1'b0, am} + {1'b0, bp} + {64'd0, (sub | cin)};
      s    = full[63:0] & mask;
      c    = full[w];
      o    = (am[w-1] == bp[w-1]) && (s[w-1] != am[w-1]);
      return {c, o, s};
   endfunction

   // ---------------- monitor ----------------
   task automatic monitor_loop();
      logic [65:0] act, held;
      logic        stall_prev;
      stall_prev = 1'b0;
      held       = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
            run        = 0;
            continue;
         end
         act = {m_if.Cout, m_if.Ovf, 32'h0, m_if.Sum};
         if (stall_prev) begin
            chk("stall_hold", act, held);
            chk("stall_valid", 66'(m_if.out_valid), 66'd1);
         end
         if (m_if.out_valid && !m_if.out_ready)
            chk("stall_in_ready", 66'(m_if.in_ready), 66'd0);
         stall_prev = m_if.out_valid && !m_if.out_ready;
         held       = act;
         if (m_if.out_valid) begin
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         if (m_if.out_valid && m_if.out_ready) begin
            if (exp_m.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL main_extra: got %h expected nothing", act);
            end else chk("main_result", act, exp_m.pop_front());
         end
         if (s1_if.out_valid) begin
            act = {s1_if.Cout, s1_if.Ovf, 48'h0, s1_if.Sum};
            if (exp_1.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL w16_extra: got %h expected nothing", act);
            end else chk("w16_result", act, exp_1.pop_front());
         end
         if (s2_if.out_valid) begin
            act = {s2_if.Cout, s2_if.Ovf, s2_if.Sum};
            if (exp_2.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL w64_extra: got %h expected nothing", act);
            end else chk("w64_result", act, exp_2.pop_front());
         end
         if (s3_if.out_valid) begin
            act = {s3_if.Cout, s3_if.Ovf, 32'h0, s3_if.Sum};
            if (exp_3.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL w32b2_extra: got %h expected nothing", act);
            end else chk("w32b2_result", act, exp_3.pop_front());
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; returns just after the accepting edge
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub, input logic [65:0] e);
      logic rdy;
      int   t;
      t = 0;
      m_if.A = a; m_if.B = b; m_if.Cin = cin; m_if.Sub = sub;
      m_if.in_valid = 1'b1;
      do begin
         @(negedge clk);
         rdy = m_if.in_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!rdy && t < 50);
      if (!rdy) begin
         n_vec++; n_err++;
         $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected accept", t);
      end else begin
         exp_m.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      m_if.in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_rand();
      logic [31:0] ra, rb;
      logic        rc, rs;
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model({32'h0, ra}, {32'h0, rb}, rc, rs, 32));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int w;
      m_if.in_valid = 1'b0; m_if.A = '0; m_if.B = '0; m_if.Cin = 1'b0; m_if.Sub = 1'b0;
      m_if.out_ready = 1'b1;
      vld_s = 1'b0; a_s = '0; b_s = '0; cin_s = 1'b0; sub_s = 1'b0;

      fork
         monitor_loop();
      join_none

      // reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 66'(m_if.out_valid), 66'd0);
      chk("rst_outputs", {m_if.Cout, m_if.Ovf, 32'h0, m_if.Sum}, 66'd0);
      chk("rst_in_ready", 66'(m_if.in_ready), 66'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // full carry chain with latency check
      send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, pk(1'b1, 1'b0, 32'h0000_0000));
      m_if.in_valid = 1'b0;
      @(negedge clk);
      chk("lat_early", 66'(m_if.out_valid), 66'd0);
      @(negedge clk);
      chk("lat_edge1", 66'(m_if.out_valid), 66'd1);
      @(posedge clk);
      #1;

      // directed vectors, back to back
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, pk(1'b0, 1'b1, 32'h8000_0000));
      send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, pk(1'b0, 1'b0, 32'hFFFF_FFFE));
      send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, pk(1'b1, 1'b1, 32'h7FFF_FFFF));
      send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, pk(1'b0, 1'b0, 32'h2345_6789));
      send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, pk(1'b1, 1'b0, 32'h0000_0000));
      send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, pk(1'b1, 1'b1, 32'h0000_0000));
      idle(4);

      // 8 back-to-back transactions, no backpressure
      max_run = 0;
      for (int i = 0; i < 8; i++) send_rand();
      idle(5);
      chk("stream_run", 66'(max_run), 66'd8);

      // 8 transactions with a 3-cycle stall mid-stream
      fork
         begin
            for (int i = 0; i < 8; i++) send_rand();
            m_if.in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1 m_if.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 m_if.out_ready = 1'b1;
         end
      join
      idle(6);

      // asynchronous reset with two results in flight
      send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, pk(1'b0, 1'b0, 32'h0000_0100));
      send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, pk(1'b1, 1'b0, 32'h0000_0000));
      m_if.in_valid = 1'b0;
      chk("inflight_valid", 66'(m_if.out_valid), 66'd1);
      #2 rst_n = 1'b0;
      exp_m.delete();
      #1;
      chk("async_rst_valid", 66'(m_if.out_valid), 66'd0);
      chk("async_rst_outputs", {m_if.Cout, m_if.Ovf, 32'h0, m_if.Sum}, 66'd0);
      chk("async_rst_in_ready", 66'(m_if.in_ready), 66'd1);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b0, pk(1'b0, 1'b0, 32'hDEAD_BEF1));
      idle(4);

      // parameter variants from a shared random stream
      for (int i = 0; i < 24; i++) begin
         vld_s = ($urandom_range(0, 3) != 0);
         if (i == 0) begin
            a_s = {64{1'b1}}; b_s = '0; cin_s = 1'b1; sub_s = 1'b0;
         end else begin
            a_s = {$urandom, $urandom}; b_s = {$urandom, $urandom};
            cin_s = 1'($urandom_range(0, 1)); sub_s = 1'($urandom_range(0, 1));
         end
         if (vld_s) begin
            exp_1.push_back(model(a_s, b_s, cin_s, sub_s, 16));
            exp_2.push_back(model(a_s, b_s, cin_s, sub_s, 64));
            exp_3.push_back(model(a_s, b_s, cin_s, sub_s, 32));
         end
         @(posedge clk);
         #1;
      end
      vld_s = 1'b0;

      // drain, bounded
      w = 0;
      while ((exp_m.size() + exp_1.size() + exp_2.size() + exp_3.size()) > 0 && w < 200) begin
         @(posedge clk);
         w++;
      end
      chk("drain_left", 66'(exp_m.size() + exp_1.size() + exp_2.size() + exp_3.size()), 66'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
